alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 68 ++++++
 rtl/alu_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundles the two requester ports, the two response ports and the shared
// ALU connection of alu_arbiter. The arbiter uses the slave modport; the
// master modport is the view seen from the requesters and the ALU.
interface alu_arbiter_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned TAGW = 4
);
  logic            req0_valid;
  logic            req0_ready;
  logic [XLEN-1:0] req0_rs1;
  logic [XLEN-1:0] req0_rs2;
  logic [2:0]      req0_funct3;
  logic            req0_funct7;
  logic [TAGW-1:0] req0_tag;

  logic            req1_valid;
  logic            req1_ready;
  logic [XLEN-1:0] req1_rs1;
  logic [XLEN-1:0] req1_rs2;
  logic [2:0]      req1_funct3;
  logic            req1_funct7;
  logic [TAGW-1:0] req1_tag;

  logic            rsp0_valid;
  logic            rsp0_ready;
  logic [XLEN-1:0] rsp0_rd;
  logic            rsp0_z;
  logic [TAGW-1:0] rsp0_tag;

  logic            rsp1_valid;
  logic            rsp1_ready;
  logic [XLEN-1:0] rsp1_rd;
  logic            rsp1_z;
  logic [TAGW-1:0] rsp1_tag;

  logic [XLEN-1:0] alu_rs1;
  logic [XLEN-1:0] alu_rs2;
  logic [2:0]      alu_funct3;
  logic            alu_funct7;
  logic [XLEN-1:0] alu_rd;
  logic            alu_z;

  modport slave (
    input  req0_valid, req0_rs1, req0_rs2, req0_funct3, req0_funct7, req0_tag,
    output req0_ready,
    input  req1_valid, req1_rs1, req1_rs2, req1_funct3, req1_funct7, req1_tag,
    output req1_ready,
    output rsp0_valid, rsp0_rd, rsp0_z, rsp0_tag,
    input  rsp0_ready,
    output rsp1_valid, rsp1_rd, rsp1_z, rsp1_tag,
    input  rsp1_ready,
    output alu_rs1, alu_rs2, alu_funct3, alu_funct7,
    input  alu_rd, alu_z
  );

  modport master (
    output req0_valid, req0_rs1, req0_rs2, req0_funct3, req0_funct7, req0_tag,
    input  req0_ready,
    output req1_valid, req1_rs1, req1_rs2, req1_funct3, req1_funct7, req1_tag,
    input  req1_ready,
    input  rsp0_valid, rsp0_rd, rsp0_z, rsp0_tag,
    output rsp0_ready,
    input  rsp1_valid, rsp1_rd, rsp1_z, rsp1_tag,
    output rsp1_ready,
    input  alu_rs1, alu_rs2, alu_funct3, alu_funct7,
    output alu_rd, alu_z
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters.
// One operation in flight at a time: IDLE (accept) -> ISSUE (ALU evaluates)
// -> RESP (hold response until taken). Arbitration is round-robin by default;
// defining ALU_ARB_FIXED_PRIO_EN makes requester 0 always win a tie.
module alu_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned TAGW = 4
) (
  input logic        clk,
  input logic        rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state;
  logic            gnt;        // requester owning the transaction in flight
  logic [XLEN-1:0] op_rs1;
  logic [XLEN-1:0] op_rs2;
  logic [2:0]      op_funct3;
  logic            op_funct7;
  logic [TAGW-1:0] op_tag;
  logic [XLEN-1:0] res_rd;
  logic            res_z;
  logic [1:0]      rsp_valid;

  logic sel_c;
  logic accept_c;
  logic rsp_fire_c;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 0 wins whenever it is valid.
  always_comb begin
    sel_c = 1'b0;
    if (!bus.req0_valid) sel_c = 1'b1;
  end
`else
  logic last_grant;

  // Round-robin: on a tie, grant the requester not served last.
  always_comb begin
    sel_c = 1'b0;
    if (bus.req0_valid && bus.req1_valid) sel_c = ~last_grant;
    else if (!bus.req0_valid)             sel_c = 1'b1;
  end
`endif

  // Accept / completion qualifiers; ready depends only on state and valids.
  always_comb begin
    accept_c   = rst_n && (state == IDLE) && (bus.req0_valid || bus.req1_valid);
    rsp_fire_c = (state == RESP) && (gnt ? bus.rsp1_ready : bus.rsp0_ready);
  end

  assign bus.req0_ready = accept_c && !sel_c;
  assign bus.req1_ready = accept_c &&  sel_c;

  // Sequencer: latch op on accept, capture ALU result, hold response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
      op_rs1    <= '0;
      op_rs2    <= '0;
      op_funct3 <= '0;
      op_funct7 <= 1'b0;
      op_tag    <= '0;
      res_rd    <= '0;
      res_z     <= 1'b0;
      rsp_valid <= 2'b00;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept_c) begin
            gnt       <= sel_c;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= sel_c;
`endif
            op_rs1    <= sel_c ? bus.req1_rs1    : bus.req0_rs1;
            op_rs2    <= sel_c ? bus.req1_rs2    : bus.req0_rs2;
            op_funct3 <= sel_c ? bus.req1_funct3 : bus.req0_funct3;
            op_funct7 <= sel_c ? bus.req1_funct7 : bus.req0_funct7;
            op_tag    <= sel_c ? bus.req1_tag    : bus.req0_tag;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          res_rd    <= bus.alu_rd;
          res_z     <= bus.alu_z;
          rsp_valid <= gnt ? 2'b10 : 2'b01;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_fire_c) begin
            rsp_valid <= 2'b00;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 2'b00;
          state     <= IDLE;
        end
      endcase
    end
  end

  // ALU is driven straight from the op registers.
  assign bus.alu_rs1    = op_rs1;
  assign bus.alu_rs2    = op_rs2;
  assign bus.alu_funct3 = op_funct3;
  assign bus.alu_funct7 = op_funct7;

  // Both response ports share the payload; only the granted one is valid.
  assign bus.rsp0_valid = rsp_valid[0];
  assign bus.rsp1_valid = rsp_valid[1];
  assign bus.rsp0_rd    = res_rd;
  assign bus.rsp1_rd    = res_rd;
  assign bus.rsp0_z     = res_z;
  assign bus.rsp1_z     = res_z;
  assign bus.rsp0_tag   = op_tag;
  assign bus.rsp1_tag   = op_tag;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a
// transaction-level model.
module tb_alu_arbiter;
  localparam int unsigned XLEN = 32;
  localparam int unsigned TAGW = 4;

  logic clk;
  logic rst_n;
  alu_arbiter_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();

  alu_arbiter #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference RV32 integer ALU, used both as the external ALU and by the model.
  function automatic logic [31:0] alu_ref(logic [2:0] f3, logic f7, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0: return f7 ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'b0, ($signed(a) < $signed(b))};
      3'd3: return {31'b0, (a < b)};
      3'd4: return a ^ b;
      3'd5: return f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  assign bus.alu_rd = alu_ref(bus.alu_funct3, bus.alu_funct7, bus.alu_rs1, bus.alu_rs2);
  assign bus.alu_z  = (alu_ref(bus.alu_funct3, bus.alu_funct7, bus.alu_rs1, bus.alu_rs2) == 32'd0);

  task automatic check1(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          port;
    logic [31:0] rd;
    logic        z;
    logic [3:0]  tag;
  } rsp_t;

  rsp_t rsp_log[$];
  bit   grants[$];
  bit   acc0, acc1;

  // Transaction-level model: phase 0 waiting, 1 ALU busy, 2 response pending.
  bit          m_ok = 1'b0;
  int          m_phase;
  bit          m_g;
  bit          m_last;
  logic [31:0] m_rs1, m_rs2, m_rd;
  logic [2:0]  m_f3;
  logic        m_f7, m_z;
  logic [3:0]  m_tag;

  function automatic bit pick(bit v0, bit v1);
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (v1 && !v0) return 1'b1;
    return 1'b0;
`else
    if (v0 && v1) return !m_last;
    return !v0;
`endif
  endfunction

  // Compare DUT to model each cycle, then advance the model across the next edge.
  always @(negedge clk) begin
    bit g, v0, v1, e0, e1;
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    g  = pick(v0, v1);
    if (m_ok) begin
      e0 = rst_n && (m_phase == 0) && v0 && !g;
      e1 = rst_n && (m_phase == 0) && v1 && g;
      check1("req0_ready", bus.req0_ready, e0);
      check1("req1_ready", bus.req1_ready, e1);
      check1("ready_excl", bus.req0_ready & bus.req1_ready, 1'b0);
      check1("rsp0_valid", bus.rsp0_valid, (m_phase == 2) && !m_g);
      check1("rsp1_valid", bus.rsp1_valid, (m_phase == 2) && m_g);
      if (m_phase == 2) begin
        check32("rsp_rd", m_g ? bus.rsp1_rd : bus.rsp0_rd, m_rd);
        check1("rsp_z", m_g ? bus.rsp1_z : bus.rsp0_z, m_z);
        check32("rsp_tag", 32'(m_g ? bus.rsp1_tag : bus.rsp0_tag), 32'(m_tag));
      end
      check32("alu_rs1", bus.alu_rs1, m_rs1);
      check32("alu_rs2", bus.alu_rs2, m_rs2);
      check32("alu_funct3", 32'(bus.alu_funct3), 32'(m_f3));
      check1("alu_funct7", bus.alu_funct7, m_f7);
    end
    acc0 = bus.req0_ready;
    acc1 = bus.req1_ready;
    if (acc0) grants.push_back(1'b0);
    if (acc1) grants.push_back(1'b1);
    if (bus.rsp0_valid && bus.rsp0_ready)
      rsp_log.push_back('{port: 1'b0, rd: bus.rsp0_rd, z: bus.rsp0_z, tag: bus.rsp0_tag});
    if (bus.rsp1_valid && bus.rsp1_ready)
      rsp_log.push_back('{port: 1'b1, rd: bus.rsp1_rd, z: bus.rsp1_z, tag: bus.rsp1_tag});

    if (!rst_n) begin
      m_ok = 1'b1; m_phase = 0; m_last = 1'b1; m_g = 1'b0;
      m_rs1 = '0; m_rs2 = '0; m_f3 = '0; m_f7 = 1'b0; m_tag = '0; m_rd = '0; m_z = 1'b0;
    end else if (m_ok) begin
      case (m_phase)
        0: if (v0 || v1) begin
          m_g   = g;
          m_last = g;
          m_rs1 = g ? bus.req1_rs1 : bus.req0_rs1;
          m_rs2 = g ? bus.req1_rs2 : bus.req0_rs2;
          m_f3  = g ? bus.req1_funct3 : bus.req0_funct3;
          m_f7  = g ? bus.req1_funct7 : bus.req0_funct7;
          m_tag = g ? bus.req1_tag : bus.req0_tag;
          m_rd  = alu_ref(m_f3, m_f7, m_rs1, m_rs2);
          m_z   = (m_rd == 32'd0);
          m_phase = 1;
        end
        1: m_phase = 2;
        default: if (m_g ? bus.rsp1_ready : bus.rsp0_ready) m_phase = 0;
      endcase
    end
  end

  // Advance one clock; requesters drop valid once accepted.
  task automatic tick();
    @(posedge clk);
    #1;
    if (acc0) bus.req0_valid = 1'b0;
    if (acc1) bus.req1_valid = 1'b0;
  endtask

  task automatic set_req(bit n, logic [2:0] f3, logic f7, logic [31:0] a, logic [31:0] b, logic [3:0] t);
    if (!n) begin
      bus.req0_valid = 1'b1; bus.req0_funct3 = f3; bus.req0_funct7 = f7;
      bus.req0_rs1 = a; bus.req0_rs2 = b; bus.req0_tag = t;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_funct3 = f3; bus.req1_funct7 = f7;
      bus.req1_rs1 = a; bus.req1_rs2 = b; bus.req1_tag = t;
    end
  endtask

  task automatic rand_req(bit n);
    logic [31:0] a, b;
    a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    set_req(n, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), a, b, 4'($urandom_range(0, 15)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    rsp_log.delete();
    grants.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_rs1 = '0; bus.req0_rs2 = '0; bus.req0_funct3 = '0; bus.req0_funct7 = 1'b0; bus.req0_tag = '0;
    bus.req1_rs1 = '0; bus.req1_rs2 = '0; bus.req1_funct3 = '0; bus.req1_funct7 = 1'b0; bus.req1_tag = '0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    tick(); tick();
    @(negedge clk);
    check1("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
    check1("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
    check32("rst_alu_rs1", bus.alu_rs1, 32'd0);
    do_reset();

    // Single ADD on requester 0.
    set_req(1'b0, 3'd0, 1'b0, 32'd20, 32'd30, 4'd3);
    @(negedge clk);
    check1("single_ready0", bus.req0_ready, 1'b1);
    tick();
    @(negedge clk);
    check1("single_issue_valid", bus.rsp0_valid, 1'b0);
    tick();
    @(negedge clk);
    check1("single_rsp_valid", bus.rsp0_valid, 1'b1);
    check32("single_rd", bus.rsp0_rd, 32'd50);
    check1("single_z", bus.rsp0_z, 1'b0);
    check32("single_tag", 32'(bus.rsp0_tag), 32'd3);
    tick();
    @(negedge clk);
    check1("single_done", bus.rsp0_valid, 1'b0);

    // Simultaneous requests straight after reset.
    do_reset();
    set_req(1'b0, 3'd0, 1'b1, 32'd8, 32'd3, 4'd1);
    set_req(1'b1, 3'd6, 1'b0, 32'd20, 32'd30, 4'd2);
    repeat (10) tick();
    check32("sim_count", 32'(rsp_log.size()), 32'd2);
    if (rsp_log.size() == 2) begin
      check1("sim_first_port", rsp_log[0].port, 1'b0);
      check32("sim_first_rd", rsp_log[0].rd, 32'd5);
      check32("sim_first_tag", 32'(rsp_log[0].tag), 32'd1);
      check1("sim_second_port", rsp_log[1].port, 1'b1);
      check32("sim_second_rd", rsp_log[1].rd, 32'd30);
      check32("sim_second_tag", 32'(rsp_log[1].tag), 32'd2);
    end

    // Zero flag on requester 1.
    rsp_log.delete();
    set_req(1'b1, 3'd0, 1'b1, 32'd20, 32'd20, 4'd7);
    repeat (6) tick();
    check32("zero_count", 32'(rsp_log.size()), 32'd1);
    if (rsp_log.size() == 1) begin
      check1("zero_port", rsp_log[0].port, 1'b1);
      check32("zero_rd", rsp_log[0].rd, 32'd0);
      check1("zero_z", rsp_log[0].z, 1'b1);
    end

    // Backpressure on response 0 while requester 1 waits.
    rsp_log.delete();
    bus.rsp0_ready = 1'b0;
    set_req(1'b0, 3'd0, 1'b0, 32'd7, 32'd9, 4'd5);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      @(negedge clk);
      seen = bus.rsp0_valid;
    end
    check1("bp_reached", seen, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) set_req(1'b1, 3'd4, 1'b0, 32'hF0, 32'h0F, 4'd6);
      @(negedge clk);
      check1("bp_valid", bus.rsp0_valid, 1'b1);
      check32("bp_rd", bus.rsp0_rd, 32'd16);
      check32("bp_tag", 32'(bus.rsp0_tag), 32'd5);
      check1("bp_ready0", bus.req0_ready, 1'b0);
      check1("bp_ready1", bus.req1_ready, 1'b0);
    end
    tick();
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    check1("bp_release_valid", bus.rsp0_valid, 1'b1);
    tick();
    @(negedge clk);
    check1("bp_after_valid", bus.rsp0_valid, 1'b0);
    check1("bp_after_ready1", bus.req1_ready, 1'b1);
    repeat (5) tick();
    check32("bp_count", 32'(rsp_log.size()), 32'd2);
    if (rsp_log.size() == 2) check32("bp_second_rd", rsp_log[1].rd, 32'hFF);

    // Reset while the operation is in ISSUE.
    do_reset();
    set_req(1'b0, 3'd0, 1'b0, 32'd11, 32'd22, 4'd9);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check32("rstmid_issue_rs1", bus.alu_rs1, 32'd11);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check32("rstmid_rs1", bus.alu_rs1, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge clk);
      check1("rstmid_no_rsp", bus.rsp0_valid | bus.rsp1_valid, 1'b0);
    end
    check32("rstmid_count", 32'(rsp_log.size()), 32'd0);

    // Both requesters continuously valid.
    do_reset();
    for (int i = 0; i < 60 && grants.size() < 6; i++) begin
      if (!bus.req0_valid) rand_req(1'b0);
      if (!bus.req1_valid) rand_req(1'b1);
      tick();
    end
    check32("prio_count", 32'(grants.size() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < grants.size(); i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      check1("prio_grant", grants[i], 1'b0);
`else
      check1("prio_grant", grants[i], 1'(i % 2));
`endif
    end

    // Randomized traffic with backpressure and occasional resets.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (!bus.req0_valid && $urandom_range(0, 2) == 0) rand_req(1'b0);
      if (!bus.req1_valid && $urandom_range(0, 2) == 0) rand_req(1'b1);
      bus.rsp0_ready = ($urandom_range(0, 3) != 0);
      bus.rsp1_ready = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
